// File: rtl/bbox_pkg.sv
// Shared types and constants for the bounding-box accumulator.
// Optional feature macro: BBOX_CENTROID_EN adds per-label x/y coordinate sums.
package bbox_pkg;

    localparam int BBOX_LABEL_W = 8;
    localparam int BBOX_COORD_W = 12;
    localparam int BBOX_COUNT_W = 20;
    localparam int BBOX_SUM_W   = BBOX_COORD_W + BBOX_COUNT_W;

    // Label 0 is background and never gets a table entry.
    localparam int BBOX_BG_LABEL = 0;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DUMP  = 1'b1
    } bbox_state_t;

    // One table entry; count == 0 marks the entry as empty.
    typedef struct packed {
        logic [BBOX_COORD_W-1:0] xmin;
        logic [BBOX_COORD_W-1:0] xmax;
        logic [BBOX_COORD_W-1:0] ymin;
        logic [BBOX_COORD_W-1:0] ymax;
        logic [BBOX_COUNT_W-1:0] count;
`ifdef BBOX_CENTROID_EN
        logic [BBOX_SUM_W-1:0]   sum_x;
        logic [BBOX_SUM_W-1:0]   sum_y;
`endif
    } bbox_entry_t;

endpackage

// File: rtl/bbox_raster_cnt.sv
// Raster x/y tracker. cur_x/cur_y are the coordinates of the pixel presented
// this cycle; the registers hold the coordinates of the last consumed pixel.
// Both coordinates saturate at their maximum value.
module bbox_raster_cnt #(
    parameter int COORD_W = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               hsync,
    input  logic               vsync,
    input  logic               clear,
    output logic [COORD_W-1:0] cur_x,
    output logic [COORD_W-1:0] cur_y
);

    localparam logic [COORD_W-1:0] COORD_MAX = '1;

    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;

    // Coordinates of the current pixel: vsync restarts the frame, hsync starts a row.
    always_comb begin
        cur_x = (x_q == COORD_MAX) ? COORD_MAX : x_q + 1'b1;
        cur_y = y_q;
        if (vsync) begin
            cur_x = '0;
            cur_y = '0;
        end else if (hsync) begin
            cur_x = '0;
            cur_y = (y_q == COORD_MAX) ? COORD_MAX : y_q + 1'b1;
        end
    end

    // Remember the last consumed pixel position; cleared at end of dump.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else if (clear) begin
            x_q <= '0;
            y_q <= '0;
        end else if (en) begin
            x_q <= cur_x;
            y_q <= cur_y;
        end
    end

endmodule

// File: rtl/bbox_accum.sv
// Per-label bounding box and pixel count over one frame of a cc label stream.
// At eof the table is scanned from label 1 upward; every non-empty entry is
// emitted as one record and cleared on acceptance.
// Optional feature macro: BBOX_CENTROID_EN (adds out_sum_x / out_sum_y).
//
// Output handshake: a record is transferred on a rising edge where
// out_valid & out_ready are both high; while out_valid is high and out_ready
// low the record holds stable, and out_valid never drops without a transfer.
module bbox_accum
    import bbox_pkg::*;
#(
    parameter int LABEL_W    = BBOX_LABEL_W,
    parameter int NUM_LABELS = 256,
    parameter int COORD_W    = BBOX_COORD_W,
    parameter int COUNT_W    = BBOX_COUNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               hsync,
    input  logic               vsync,
    input  logic               eof,
    input  logic [LABEL_W-1:0] label,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LABEL_W-1:0] out_label,
    output logic [COORD_W-1:0] out_xmin,
    output logic [COORD_W-1:0] out_xmax,
    output logic [COORD_W-1:0] out_ymin,
    output logic [COORD_W-1:0] out_ymax,
    output logic [COUNT_W-1:0] out_count,
`ifdef BBOX_CENTROID_EN
    output logic [BBOX_SUM_W-1:0] out_sum_x,
    output logic [BBOX_SUM_W-1:0] out_sum_y,
`endif
    output logic               frame_done,
    output bbox_state_t        dbg_state
);

    bbox_state_t        state_q, state_d;
    logic [LABEL_W-1:0] idx_q, idx_d;
    logic               frame_done_d;

    bbox_entry_t        tbl [NUM_LABELS];
    bbox_entry_t        old_e, new_e, dump_e;

    logic [COORD_W-1:0] cur_x, cur_y;
    logic               pix_take, pix_upd, accept;

    assign pix_take  = en && (state_q == ST_ACCUM);
    assign pix_upd   = pix_take && (label != LABEL_W'(BBOX_BG_LABEL));
    assign dump_e    = tbl[idx_q];
    assign out_valid = (state_q == ST_DUMP) && (dump_e.count != '0);
    assign accept    = out_valid && out_ready;
    assign busy      = (state_q == ST_DUMP);
    assign dbg_state = state_q;

    bbox_raster_cnt #(.COORD_W(COORD_W)) u_raster (
        .clk   (clk),
        .reset (reset),
        .en    (pix_take),
        .hsync (hsync),
        .vsync (vsync),
        .clear (frame_done_d),
        .cur_x (cur_x),
        .cur_y (cur_y)
    );

    // Merge the current pixel into its label's entry (read straight from the
    // register array, so back-to-back pixels of one label see fresh data).
    always_comb begin
        old_e = tbl[label];
        new_e = old_e;
        if (old_e.count == '0) begin
            new_e.xmin  = cur_x;
            new_e.xmax  = cur_x;
            new_e.ymin  = cur_y;
            new_e.ymax  = cur_y;
            new_e.count = BBOX_COUNT_W'(1);
`ifdef BBOX_CENTROID_EN
            new_e.sum_x = BBOX_SUM_W'(cur_x);
            new_e.sum_y = BBOX_SUM_W'(cur_y);
`endif
        end else begin
            if (cur_x < old_e.xmin) new_e.xmin = cur_x;
            if (cur_x > old_e.xmax) new_e.xmax = cur_x;
            if (cur_y < old_e.ymin) new_e.ymin = cur_y;
            if (cur_y > old_e.ymax) new_e.ymax = cur_y;
            if (old_e.count != '1) new_e.count = old_e.count + 1'b1;
`ifdef BBOX_CENTROID_EN
            new_e.sum_x = old_e.sum_x + BBOX_SUM_W'(cur_x);
            new_e.sum_y = old_e.sum_y + BBOX_SUM_W'(cur_y);
`endif
        end
    end

    // Table: accumulate in ACCUM, clear the retired entry on acceptance in DUMP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_LABELS; i++) tbl[i] <= '0;
        end else if (pix_upd) begin
            tbl[label] <= new_e;
        end else if (accept) begin
            tbl[idx_q] <= '0;
        end
    end

    // Next state: eof enters DUMP at label 1; empty entries skip in one cycle.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                if (en && eof) begin
                    state_d = ST_DUMP;
                    idx_d   = LABEL_W'(1);
                end
            end
            ST_DUMP: begin
                if ((dump_e.count == '0) || accept) begin
                    if (idx_q == LABEL_W'(NUM_LABELS - 1)) begin
                        state_d      = ST_ACCUM;
                        idx_d        = LABEL_W'(1);
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    // State, scan index and the frame_done pulse register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_ACCUM;
            idx_q      <= LABEL_W'(1);
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            frame_done <= frame_done_d;
        end
    end

    // Record outputs are zero whenever no record is offered.
    always_comb begin
        out_label = '0;
        out_xmin  = '0;
        out_xmax  = '0;
        out_ymin  = '0;
        out_ymax  = '0;
        out_count = '0;
`ifdef BBOX_CENTROID_EN
        out_sum_x = '0;
        out_sum_y = '0;
`endif
        if (out_valid) begin
            out_label = idx_q;
            out_xmin  = dump_e.xmin;
            out_xmax  = dump_e.xmax;
            out_ymin  = dump_e.ymin;
            out_ymax  = dump_e.ymax;
            out_count = dump_e.count;
`ifdef BBOX_CENTROID_EN
            out_sum_x = dump_e.sum_x;
            out_sum_y = dump_e.sum_y;
`endif
        end
    end

endmodule

// File: tb/tb_bbox_accum.sv
// Bench for bbox_accum: frame driver tasks, a per-label behavioural model,
// an expected-record queue checked every cycle, and a final report.
module tb_bbox_accum;
    import bbox_pkg::*;

`ifdef BBOX_CENTROID_EN
    localparam int REC_W = 140;
`else
    localparam int REC_W = 76;
`endif
    localparam int CMAX = 4095;
    localparam int NMAX = (1 << 20) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, hsync, vsync, eof, out_ready;
    logic [7:0]  label;
    logic        busy, out_valid, frame_done;
    logic [7:0]  out_label;
    logic [11:0] out_xmin, out_xmax, out_ymin, out_ymax;
    logic [19:0] out_count;
    logic [31:0] out_sum_x, out_sum_y;
    bbox_state_t dbg_state;

    int checks = 0;
    int errors = 0;
    int pending_done = 0;
    bit ready_rand = 0;
    logic [REC_W-1:0] exp_q[$];

    // Model table: plain per-label arrays.
    int     m_cnt [256];
    int     m_xmin[256], m_xmax[256], m_ymin[256], m_ymax[256];
    longint m_sx  [256], m_sy  [256];

    bbox_accum dut (
        .clk(clk), .reset(rst), .en(en), .hsync(hsync), .vsync(vsync), .eof(eof),
        .label(label), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_label(out_label), .out_xmin(out_xmin), .out_xmax(out_xmax),
        .out_ymin(out_ymin), .out_ymax(out_ymax), .out_count(out_count),
`ifdef BBOX_CENTROID_EN
        .out_sum_x(out_sum_x), .out_sum_y(out_sum_y),
`endif
        .frame_done(frame_done), .dbg_state(dbg_state)
    );

`ifndef BBOX_CENTROID_EN
    assign out_sum_x = '0;
    assign out_sum_y = '0;
`endif

    // Clock
    always #5 clk = ~clk;

    function automatic logic [REC_W-1:0] rec_pack(input int l, xmn, xmx, ymn, ymx, cnt,
                                                  input longint sx, sy);
        logic [REC_W-1:0] r;
`ifdef BBOX_CENTROID_EN
        r = {8'(l), 12'(xmn), 12'(xmx), 12'(ymn), 12'(ymx), 20'(cnt), 32'(sx), 32'(sy)};
`else
        r = {8'(l), 12'(xmn), 12'(xmx), 12'(ymn), 12'(ymx), 20'(cnt)};
        if (sx < 0 && sy < 0) r = '0;
`endif
        return r;
    endfunction

    logic [REC_W-1:0] act_rec;
    assign act_rec = rec_pack(int'(out_label), int'(out_xmin), int'(out_xmax), int'(out_ymin),
                              int'(out_ymax), int'(out_count), longint'(out_sum_x),
                              longint'(out_sum_y));

    task automatic chk(input string name, input logic [REC_W-1:0] got, exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Model
    task automatic model_clear();
        for (int i = 0; i < 256; i++) begin
            m_cnt[i] = 0; m_sx[i] = 0; m_sy[i] = 0;
        end
    endtask

    task automatic model_pixel(input int l, input int x, input int y);
        if (l == 0) return;
        if (m_cnt[l] == 0) begin
            m_xmin[l] = x; m_xmax[l] = x; m_ymin[l] = y; m_ymax[l] = y;
        end else begin
            if (x < m_xmin[l]) m_xmin[l] = x;
            if (x > m_xmax[l]) m_xmax[l] = x;
            if (y < m_ymin[l]) m_ymin[l] = y;
            if (y > m_ymax[l]) m_ymax[l] = y;
        end
        if (m_cnt[l] < NMAX) m_cnt[l]++;
        m_sx[l] += x;
        m_sy[l] += y;
    endtask

    task automatic model_dump();
        for (int l = 1; l < 256; l++)
            if (m_cnt[l] != 0)
                exp_q.push_back(rec_pack(l, m_xmin[l], m_xmax[l], m_ymin[l], m_ymax[l],
                                         m_cnt[l], m_sx[l], m_sy[l]));
        model_clear();
    endtask

    // Driver
    task automatic px(input logic e, hs, vs, eo, input logic [7:0] lab);
        en = e; hsync = hs; vsync = vs; eof = eo; label = lab;
        @(posedge clk); #1;
        en = 0; hsync = 0; vsync = 0; eof = 0; label = 0;
    endtask

    function automatic int lab_at(input int mode, input int x, input int y);
        int r;
        case (mode)
            1: return ((x == 1 && y == 1) || (x == 2 && y == 1) || (x == 1 && y == 2)) ? 5 : 0;
            2: return 0;
            3: return (x == 1 && y == 0) ? 3 : ((x == 2 && y == 1) ? 200 : 0);
            4: return (y == 0 && x <= 2) ? 9 : 0;
            5: return ((x == 2 && y == 0) || (x == 4 && y == 2)) ? 7 : 0;
            6: return (x == 4094) ? 1 : ((x == 4097 || x == 4099) ? 2 : 0);
            7: return (x == 0 && y == 0) ? 10 : ((x == 3 && y == 1) ? 20 : 0);
            default: begin
                r = $urandom_range(0, 9);
                if (r < 4) return 0;
                if (r < 8) return $urandom_range(1, 5);
                if (r == 8) return 255;
                return $urandom_range(1, 255);
            end
        endcase
    endfunction

    task automatic run_frame(input int w, h, mode, input bit send_eof, gaps);
        int l;
        for (int y = 0; y < h; y++)
            for (int x = 0; x < w; x++) begin
                if (gaps) repeat ($urandom_range(0, 2)) px(0, 0, 0, 0, 0);
                l = lab_at(mode, x, y);
                model_pixel(l, (x > CMAX) ? CMAX : x, (y > CMAX) ? CMAX : y);
                px(1, x == 0, x == 0 && y == 0, send_eof && x == w - 1 && y == h - 1, 8'(l));
            end
        if (send_eof) begin
            model_dump();
            pending_done++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || pending_done > 0) && n < 6000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("dump_timeout", REC_W'(n < 6000), REC_W'(1));
    endtask

    // Random consumer back-pressure
    always begin
        @(posedge clk); #1;
        if (ready_rand) out_ready = 1'($urandom_range(0, 1));
    end

    // Scoreboard: checks the outputs every cycle against the expected queue
    bit               prev_stall = 0;
    logic [REC_W-1:0] prev_rec;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (en) chk("en_during_busy", REC_W'(busy), REC_W'(0));
            chk("busy", REC_W'(busy), REC_W'((pending_done > 0) && !frame_done));
            if (frame_done) begin
                chk("frame_done_expected", REC_W'(pending_done > 0 && exp_q.size() == 0), REC_W'(1));
                if (pending_done > 0) pending_done--;
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_record", act_rec, '0);
                end else begin
                    chk("record", act_rec, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (prev_stall) begin
                chk("stall_valid", REC_W'(out_valid), REC_W'(1));
                chk("stall_hold", act_rec, prev_rec);
            end
            prev_stall = out_valid && !out_ready;
            prev_rec   = act_rec;
        end
    end

    // Test sequence
    initial begin
        int  k;
        bit  found;
        rst = 1; en = 0; hsync = 0; vsync = 0; eof = 0; label = 0; out_ready = 0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {act_rec[REC_W-4:0], busy, out_valid, frame_done}, '0);
        @(posedge clk); #1;
        rst = 0;

        // Small 4x4 frame, one object
        run_frame(4, 4, 1, 1, 0);
        chk("pin_label5_qsize", REC_W'(exp_q.size()), REC_W'(1));
        chk("pin_label5", exp_q[0], rec_pack(5, 1, 2, 1, 2, 3, 4, 4));
        out_ready = 1;
        wait_idle();

        // All-zero 8x2 frame: no records, dump length
        run_frame(8, 2, 2, 1, 0);
        k = 0; found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (frame_done) found = 1; else k++;
        end
        chk("empty_dump_cycles", REC_W'(found ? k : -1), REC_W'(255));
        wait_idle();

        // Labels 3 and 200 with a 10-cycle consumer stall
        out_ready = 0;
        run_frame(4, 2, 3, 1, 0);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (out_valid) found = 1;
        end
        chk("stall_first_valid", REC_W'(found), REC_W'(1));
        chk("stall_first_label", REC_W'(out_label), REC_W'(3));
        repeat (10) @(negedge clk);
        chk("stall_label_held", REC_W'(out_label), REC_W'(3));
        @(posedge clk); #1;
        out_ready = 1;
        wait_idle();

        // Same label on three consecutive pixels
        out_ready = 0;
        run_frame(4, 2, 4, 1, 0);
        chk("pin_hazard", exp_q[0], rec_pack(9, 0, 2, 0, 0, 3, 3, 0));
        out_ready = 1;
        wait_idle();

`ifdef BBOX_CENTROID_EN
        out_ready = 0;
        run_frame(6, 3, 5, 1, 0);
        chk("pin_centroid", exp_q[0], rec_pack(7, 2, 4, 0, 2, 2, 6, 2));
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (out_valid) found = 1;
        end
        chk("sum_x", REC_W'(out_sum_x), REC_W'(6));
        chk("sum_y", REC_W'(out_sum_y), REC_W'(2));
        @(posedge clk); #1;
        out_ready = 1;
        wait_idle();
`endif

        // Long row: x saturates at 4095
        out_ready = 0;
        run_frame(4100, 1, 6, 1, 0);
        chk("pin_sat_qsize", REC_W'(exp_q.size()), REC_W'(2));
        chk("pin_sat_l1", exp_q[0], rec_pack(1, 4094, 4094, 0, 0, 1, 4094, 0));
        chk("pin_sat_l2", exp_q[1], rec_pack(2, 4095, 4095, 0, 0, 2, 8190, 0));
        out_ready = 1;
        wait_idle();

        // Mid-frame vsync keeps the table, then random frames
        ready_rand = 1;
        run_frame(5, 3, 0, 0, 1);
        run_frame(6, 2, 0, 1, 1);
        wait_idle();
        for (int f = 0; f < 8; f++) begin
            run_frame($urandom_range(4, 16), $urandom_range(2, 8), 0, 1, f[0]);
            wait_idle();
        end

        // Reset during the dump, after the first record is accepted
        ready_rand = 0;
        @(posedge clk); #1;
        out_ready = 1;
        run_frame(4, 2, 7, 1, 0);
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (out_valid && out_label == 8'd10) found = 1;
        end
        chk("rst_first_record", REC_W'(found), REC_W'(1));
        @(posedge clk); #1;
        rst = 1;
        exp_q.delete();
        pending_done = 0;
        model_clear();
        @(negedge clk);
        chk("rst_valid_drop", REC_W'(out_valid), REC_W'(0));
        chk("rst_busy_drop", REC_W'(busy), REC_W'(0));
        @(posedge clk); #1;
        rst = 0;
        repeat (300) @(posedge clk);
        #1;
        run_frame(4, 2, 2, 1, 0);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
